dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 1 KiB byte-addressed data memory (dm).
- Requester 0 is the CPU load/store stage; requester 1 is the debug/DMA loader.
- Grants one access at a time, drives the memory's addr/din/we/sel pins from registered state, captures read data, and returns a one-cycle ack per transaction.

Parameters:
- RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins ties.
- AW, default 10: byte address width; must match the memory (1024 bytes).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 access request
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_sel  in  1  requester 0 size, DM_WORD or DM_BYTE from defines.v
- m0_addr  in  AW  requester 0 byte address
- m0_wdata  in  32  requester 0 write data (byte writes use [7:0])
- m0_ack  out  1  requester 0 transaction complete, one-cycle pulse
- m0_rdata  out  32  requester 0 read data, valid while m0_ack=1
- m0_err  out  1  requester 0 alignment error, valid while m0_ack=1
- m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as m0_* for requester 1
- dm_addr  out  AW  to memory addr
- dm_din  out  32  to memory din
- dm_we  out  1  to memory WriteEn
- dm_sel  out  1  to memory sel
- dm_dout  in  32  from memory dout (combinational read)

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request pending: stay in IDLE.
  - A request is pending: latch winner id, we, sel, addr, wdata into internal registers, then go to ACCESS.
- ACCESS:
  - dm_addr/dm_din/dm_sel are driven from the latched registers.
  - dm_we equals the latched we and is high only in this state.
  - At the clock edge, dm_dout is captured into the rdata register; the memory write commits at the same edge.
  - Next state is DONE.
- DONE:
  - The winner's ack=1 and rdata is driven with the captured value; the loser's ack=0.
  - Next state is IDLE.
  - Fixed latency: request sampled in IDLE at cycle N, memory access in cycle N+1, ack in cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Handshake:
  - A requester holds req and all its request fields stable until its ack.
  - A req still high in the cycle after ack counts as a new request.
  - Changing fields while waiting is illegal; behaviour is undefined.
- Arbitration, evaluated in IDLE only:
  - Single requester: it wins.
  - Both requesting with RR_EN=1: the requester not granted last wins. The last_grant register resets to 1, so requester 0 wins the first tie.
  - Both requesting with RR_EN=0: requester 0 wins.
- Outputs and read data:
  - Outside ACCESS: dm_we=0, dm_addr=0, dm_din=0, dm_sel=DM_WORD.
  - Byte reads return the memory's sign-extended byte unchanged; the arbiter does not alter read data.
  - m*_rdata is zero except during that requester's ack cycle.
- Reset:
  - Outputs after reset: state=IDLE, all ack=0, all err=0, all rdata=0, dm_* at idle values, last_grant=1.
  - Reset mid-transaction aborts it with no ack.
  - dm_we is gated combinationally with !reset, so reset high during ACCESS causes no memory write.
- Address wrap: word addresses are forwarded as-is; the arbiter does no wrap logic.

Optional Feature:
- Macro: DM_ARB_ALIGN_CHECK_EN.
- With the macro defined:
  - A word access (sel=DM_WORD) with addr[1:0]!=0 is latched as an error transaction.
  - In ACCESS, dm_we is forced to 0 and the dm_* pins stay at idle values.
  - In DONE, ack=1, err=1, rdata=0.
  - Latency is unchanged. Byte accesses are never flagged.
- Without the macro: no check is made; m0_err/m1_err are tied 0 and unaligned word accesses are forwarded to memory unchanged.

Test Plan:
- Reset, then m0 word write addr=0x010 wdata=0xDEADBEEF -> dm_we=1 only in cycle N+1 with dm_addr=0x010; m0_ack pulses at N+2. A following m0 word read of 0x010 returns m0_rdata=0xDEADBEEF.
- m1 byte write addr=0x3FF wdata=0x00000080, then m1 byte read 0x3FF -> m1_rdata=0xFFFFFF80; m0_ack stays 0 throughout.
- m0 and m1 both requesting continuously with RR_EN=1 -> grants alternate m0, m1, m0, m1; each ack is 3 cycles apart. With RR_EN=0 -> every tie goes to m0, and m1 is granted only in a cycle where m0_req=0.
- Reset asserted during ACCESS of an m0 word write to 0x020 with 0x12345678 -> no ack. A later read of 0x020 returns the prior contents (0x00000000 after init).
- With DM_ARB_ALIGN_CHECK_EN, m0 word write addr=0x006 -> dm_we never asserted; at N+2, m0_ack=1, m0_err=1, m0_rdata=0. A byte write to 0x006 succeeds with err=0.
- Back-to-back: m0_req held high across its ack with new fields -> second transaction begins in the IDLE cycle right after DONE and is acked 3 cycles after the first ack.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester arbiter/sequencer for the 1 KiB data memory.
// Optional word-alignment check enabled by defining DM_ARB_ALIGN_CHECK_EN.
module dm_arbiter #(
   parameter int RR_EN = 1,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_sel,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_ack,
   output logic [31:0]   m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_sel,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   output logic          m1_ack,
   output logic [31:0]   m1_rdata,
   output logic          m1_err,
   output logic [AW-1:0] dm_addr,
   output logic [31:0]   dm_din,
   output logic          dm_we,
   output logic          dm_sel,
   input  logic [31:0]   dm_dout
);
   localparam logic DM_WORD = 1'b0;
   localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          gnt_q, gnt_d, last_q, last_d, we_q, we_d, sel_q, sel_d, err_q, err_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic          win, go, bad, w_sel, acc, done;
   logic [AW-1:0] w_addr;

   always_comb begin
      // On a tie, round-robin picks m1 only when m0 was granted last.
      win     = m1_req & (~m0_req | ((RR_EN != 0) & ~last_q));
      go      = (state_q == IDLE) & (m0_req | m1_req);
      w_sel   = win ? m1_sel : m0_sel;
      w_addr  = win ? m1_addr : m0_addr;
`ifdef DM_ARB_ALIGN_CHECK_EN
      bad     = (w_sel == DM_WORD) && (w_addr[1:0] != 2'b00);
`else
      bad     = 1'b0;
`endif
      state_d = (state_q == IDLE) ? (go ? ACCESS : IDLE) : (state_q == ACCESS) ? DONE : IDLE;
      gnt_d   = go ? win : gnt_q;
      last_d  = go ? win : last_q;
      we_d    = go ? (win ? m1_we : m0_we) : we_q;
      sel_d   = go ? w_sel : sel_q;
      addr_d  = go ? w_addr : addr_q;
      wdata_d = go ? (win ? m1_wdata : m0_wdata) : wdata_q;
      err_d   = go ? bad : err_q;
      rdata_d = (state_q == ACCESS) ? (err_q ? 32'd0 : dm_dout) : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         sel_q   <= DM_WORD;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Error transactions keep the memory pins idle; reset blocks any in-flight write.
   assign acc      = (state_q == ACCESS) & ~err_q;
   assign done     = (state_q == DONE);
   assign dm_we    = acc & we_q & ~reset;
   assign dm_addr  = acc ? addr_q : '0;
   assign dm_din   = acc ? wdata_q : 32'd0;
   assign dm_sel   = acc ? sel_q : DM_WORD;
   assign m0_ack   = done & ~gnt_q;
   assign m1_ack   = done & gnt_q;
   assign m0_rdata = m0_ack ? rdata_q : 32'd0;
   assign m1_rdata = m1_ack ? rdata_q : 32'd0;
   assign m0_err   = m0_ack & err_q;
   assign m1_err   = m1_ack & err_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a byte-array memory model.
// u0 is the round-robin build, u1 the fixed-priority build sharing the same requests.
module tb_dm_arbiter;
   localparam logic DM_WORD = 1'b0, DM_BYTE = 1'b1;

   logic clk = 1'b0, reset = 1'b1;
   logic m0_req = 0, m0_we = 0, m0_sel = 0, m1_req = 0, m1_we = 0, m1_sel = 0;
   logic [9:0] m0_addr = 0, m1_addr = 0;
   logic [31:0] m0_wdata = 0, m1_wdata = 0;
   logic m0_ack, m0_err, m1_ack, m1_err, dm_we, dm_sel;
   logic [31:0] m0_rdata, m1_rdata, dm_din, dm_dout;
   logic [9:0] dm_addr;
   logic f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_dm_we, f_dm_sel;
   logic [31:0] f_m0_rdata, f_m1_rdata, f_dm_din;
   logic [9:0] f_dm_addr;
   logic [7:0] mem [0:1023] = '{default: 8'h00};

   int checks = 0, errors = 0;
   int t_lat, t_wecyc;
   logic [31:0] t_rd;
   logic [9:0] t_wa;
   logic t_er, t_other;

   dm_arbiter #(.RR_EN(1), .AW(10)) u0 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_sel(dm_sel), .dm_dout(dm_dout)
   );

   dm_arbiter #(.RR_EN(0), .AW(10)) u1 (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
      .dm_addr(f_dm_addr), .dm_din(f_dm_din), .dm_we(f_dm_we), .dm_sel(f_dm_sel), .dm_dout(32'd0)
   );

   always #5 clk = ~clk;

   // Little-endian memory, sign-extended byte reads, commits on the rising edge.
   always_comb
      dm_dout = (dm_sel == DM_BYTE) ? {{24{mem[dm_addr][7]}}, mem[dm_addr]}
              : {mem[dm_addr + 10'd3], mem[dm_addr + 10'd2], mem[dm_addr + 10'd1], mem[dm_addr]};

   always @(posedge clk)
      if (dm_we) begin
         mem[dm_addr] <= dm_din[7:0];
         if (dm_sel == DM_WORD) begin
            mem[dm_addr + 10'd1] <= dm_din[15:8];
            mem[dm_addr + 10'd2] <= dm_din[23:16];
            mem[dm_addr + 10'd3] <= dm_din[31:24];
         end
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit m, input logic r, input logic w, input logic s,
                        input logic [9:0] a, input logic [31:0] d);
      if (m) begin
         m1_req = r; m1_we = w; m1_sel = s; m1_addr = a; m1_wdata = d;
      end else begin
         m0_req = r; m0_we = w; m0_sel = s; m0_addr = a; m0_wdata = d;
      end
   endtask

   task automatic txn(input bit m, input logic w, input logic s,
                      input logic [9:0] a, input logic [31:0] d);
      drive(m, 1'b1, w, s, a, d);
      t_lat = -1; t_wecyc = -1; t_wa = '0; t_other = 1'b0; t_rd = '0; t_er = 1'b0;
      for (int c = 1; c <= 8 && t_lat < 0; c++) begin
         @(posedge clk); #1;
         if (dm_we && t_wecyc < 0) begin
            t_wecyc = c;
            t_wa = dm_addr;
         end
         if (m ? m0_ack : m1_ack) t_other = 1'b1;
         if (m ? m1_ack : m0_ack) begin
            t_lat = c;
            t_rd = m ? m1_rdata : m0_rdata;
            t_er = m ? m1_err : m0_err;
         end
      end
      drive(m, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int a1, a2, n, fn0, fn1, f_m1c;
      int ack_c [4];
      int ack_w [4];
      logic [31:0] rd2, rr_rd [4];
      logic seen;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
      chk("rst_errs", {30'd0, m0_err, m1_err}, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      chk("rst_dm", {dm_din[21:0], dm_addr}, 32'd0);
      chk("rst_dm_ctl", {30'd0, dm_we, dm_sel}, {30'd0, 1'b0, DM_WORD});

      txn(0, 1, DM_WORD, 10'h010, 32'hDEADBEEF);
      chk("w0_lat", t_lat, 2);
      chk("w0_wecyc", t_wecyc, 1);
      chk("w0_addr", t_wa, 10'h010);
      chk("w0_other", t_other, 0);
      txn(0, 0, DM_WORD, 10'h010, 32'd0);
      chk("r0_data", t_rd, 32'hDEADBEEF);
      chk("r0_nowe", t_wecyc, -1);

      txn(1, 1, DM_BYTE, 10'h3FF, 32'h00000080);
      chk("w1_lat", t_lat, 2);
      chk("w1_m0ack", t_other, 0);
      txn(1, 0, DM_BYTE, 10'h3FF, 32'd0);
      chk("r1_data", t_rd, 32'hFFFFFF80);
      chk("r1_m0ack", t_other, 0);

      txn(0, 1, DM_WORD, 10'h006, 32'hCAFEF00D);
      chk("ua_lat", t_lat, 2);
`ifdef DM_ARB_ALIGN_CHECK_EN
      chk("ua_nowe", t_wecyc, -1);
      chk("ua_err", t_er, 1);
      chk("ua_rdata", t_rd, 32'd0);
`else
      chk("ua_we", t_wecyc, 1);
      chk("ua_err", t_er, 0);
`endif
      txn(0, 1, DM_BYTE, 10'h006, 32'h0000005A);
      chk("ub_we", t_wecyc, 1);
      chk("ub_err", t_er, 0);
      txn(0, 0, DM_BYTE, 10'h006, 32'd0);
      chk("ub_rd", t_rd, 32'h0000005A);

      // Abort a write while the memory access is in flight.
      drive(0, 1, 1, DM_WORD, 10'h020, 32'h12345678);
      @(posedge clk); #1;
      chk("ab_access_we", dm_we, 1);
      reset = 1'b1;
      #1 chk("ab_gated_we", dm_we, 0);
      drive(0, 0, 0, 0, 10'd0, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen |= m0_ack | m1_ack;
      end
      chk("ab_noack", seen, 0);
      txn(0, 0, DM_WORD, 10'h020, 32'd0);
      chk("ab_rd", t_rd, 32'h00000000);

      // Back-to-back: req held through ack with new fields.
      drive(0, 1, 1, DM_WORD, 10'h030, 32'h11112222);
      a1 = -1; a2 = -1; rd2 = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (m0_ack && a1 < 0) begin
            a1 = c;
            drive(0, 1, 0, DM_WORD, 10'h030, 32'd0);
         end else if (m0_ack && a2 < 0) begin
            a2 = c;
            rd2 = m0_rdata;
            drive(0, 0, 0, 0, 10'd0, 32'd0);
         end
      end
      chk("b2b_first", a1, 2);
      chk("b2b_second", a2, 5);
      chk("b2b_rd", rd2, 32'h11112222);

      // Continuous tie: u0 alternates from m0, u1 always picks m0.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      drive(0, 1, 0, DM_WORD, 10'h010, 32'd0);
      drive(1, 1, 0, DM_BYTE, 10'h3FF, 32'd0);
      n = 0; fn0 = 0; fn1 = 0; f_m1c = -1;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         if (c <= 11 && (m0_ack || m1_ack) && n < 4) begin
            ack_c[n] = c;
            ack_w[n] = m1_ack ? 1 : 0;
            rr_rd[n] = m1_ack ? m1_rdata : m0_rdata;
            n++;
         end
         if (c <= 11 && f_m0_ack) fn0++;
         if (c <= 11 && f_m1_ack) fn1++;
         if (c > 11 && f_m1_ack && f_m1c < 0) f_m1c = c;
         if (c == 11) drive(0, 0, 0, 0, 10'd0, 32'd0);
      end
      drive(1, 0, 0, 0, 10'd0, 32'd0);
      chk("rr_count", n, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_cyc%0d", k), (k < n) ? ack_c[k] : -1, 2 + 3 * k);
         chk($sformatf("rr_who%0d", k), (k < n) ? ack_w[k] : -1, k % 2);
         chk($sformatf("rr_rd%0d", k), (k < n) ? rr_rd[k] : 32'd0,
             (k % 2) ? 32'hFFFFFF80 : 32'hDEADBEEF);
      end
      chk("fp_m0_acks", fn0, 4);
      chk("fp_m1_acks", fn1, 0);
      chk("fp_m1_cyc", f_m1c, 14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
